// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall generator: memory wait-states, multi-cycle MDU and debug halt/step.
// Optional macro STALL_PERF_EN builds a saturating stall-cycle counter on stall_cycles.
module pipe_stall_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 33,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        dmem_valid,
  output logic        mem_err,
  input  logic        ex_mdu_start,
  input  logic        ex_mdu_div,
  output logic        mdu_done,
  input  logic        dbg_halt,
  input  logic        dbg_step,
  output logic        pause,
  output logic [31:0] stall_cycles
);

  localparam int MDU_MAX = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
  localparam int CNT_W   = $clog2(MDU_MAX);
  localparam int WCNT_W  = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {M_IDLE, M_WAIT, M_DONE} mem_state_t;
  typedef enum logic [1:0] {D_IDLE, D_BUSY, D_DONE} mdu_state_t;

  mem_state_t         m_state, m_next;
  mdu_state_t         d_state, d_next;
  logic [WCNT_W-1:0]  wcnt, wcnt_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               err_next;
  logic               halted, step_pend, released;
  logic               timeout_hit, mem_stall, mdu_stall, halt_stall;

  // Stall decode: registered state combined with this cycle's inputs.
  assign timeout_hit = (m_state == M_WAIT) && (wcnt == WCNT_W'(MEM_TIMEOUT - 1));
  assign dmem_valid  = rst && mem_req && (m_state != M_DONE);
  assign mem_stall   = dmem_valid && !mem_ack && !timeout_hit;
  assign mdu_done    = (d_state == D_BUSY) && (cnt == CNT_W'(1));
  assign mdu_stall   = ((d_state == D_IDLE) && ex_mdu_start) ||
                       ((d_state == D_BUSY) && (cnt != CNT_W'(1)));
  assign released    = halted && step_pend && !mem_stall && !mdu_stall;
  assign halt_stall  = halted && !released;
  assign pause       = rst && (mem_stall || mdu_stall || halt_stall);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    m_next    = m_state;
    wcnt_next = wcnt;
    err_next  = mem_err;
    unique case (m_state)
      M_IDLE: if (mem_req) begin
        if (mem_ack) begin
          if (pause) m_next = M_DONE;
        end else begin
          m_next    = M_WAIT;
          // The request cycle itself already counts as the first wait cycle.
          wcnt_next = WCNT_W'(1);
        end
      end
      M_WAIT: begin
        wcnt_next = wcnt + 1'b1;
        if (mem_ack || timeout_hit) m_next = pause ? M_DONE : M_IDLE;
        if (timeout_hit) err_next = 1'b1;
      end
      M_DONE:  if (!pause) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  always_comb begin
    d_next   = d_state;
    cnt_next = cnt;
    unique case (d_state)
      D_IDLE: if (ex_mdu_start) begin
        d_next   = D_BUSY;
        cnt_next = ex_mdu_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
      end
      D_BUSY: begin
        cnt_next = cnt - 1'b1;
        if (cnt == CNT_W'(1)) d_next = pause ? D_DONE : D_IDLE;
      end
      D_DONE:  if (!pause) d_next = D_IDLE;
      default: d_next = D_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state   <= M_IDLE;
      wcnt      <= '0;
      mem_err   <= 1'b0;
      d_state   <= D_IDLE;
      cnt       <= '0;
      halted    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      m_state   <= m_next;
      wcnt      <= wcnt_next;
      mem_err   <= err_next;
      d_state   <= d_next;
      cnt       <= cnt_next;
      halted    <= dbg_halt;
      // A step landing in the released cycle stays pending for the next advance.
      step_pend <= (step_pend && !released) || (dbg_step && halted);
    end
  end

`ifdef STALL_PERF_EN
  logic [31:0] perf_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cnt <= '0;
    end else if (pause && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Randomized self-checking bench for pipe_stall_ctrl against a cycle-level behavioural model,
// preceded by directed scenarios for memory, MDU, timeout, reset and halt/step.
module tb_pipe_stall_ctrl;

  localparam int MUL_N = 4;
  localparam int DIV_N = 33;
  localparam int TMO   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req, mem_ack, ex_mdu_start, ex_mdu_div, dbg_halt, dbg_step;
  logic        dmem_valid, mem_err, mdu_done, pause;
  logic [31:0] stall_cycles;

  pipe_stall_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .dmem_valid   (dmem_valid),
    .mem_err      (mem_err),
    .ex_mdu_start (ex_mdu_start),
    .ex_mdu_div   (ex_mdu_div),
    .mdu_done     (mdu_done),
    .dbg_halt     (dbg_halt),
    .dbg_step     (dbg_step),
    .pause        (pause),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: memory tracked as cycles-since-request, MDU as cycles left to done.
  int          m_age;
  bit          m_hold, m_err;
  int          d_left;
  bit          d_hold;
  bit          halted_m, pend_m;
  logic [31:0] perf_m;
  bit          e_valid, e_to, e_ms, e_ds, e_hs, e_pause, e_done;

  task automatic model_reset();
    m_age = 0; m_hold = 0; m_err = 0;
    d_left = 0; d_hold = 0;
    halted_m = 0; pend_m = 0; perf_m = '0;
  endtask

  task automatic model_eval();
    e_to    = (m_age == TMO - 1);
    e_valid = rst && mem_req && !m_hold;
    e_ms    = e_valid && !mem_ack && !e_to;
    e_done  = (d_left == 1);
    e_ds    = (d_left > 1) || (d_left == 0 && !d_hold && ex_mdu_start);
    e_hs    = halted_m && !(pend_m && !e_ms && !e_ds);
    e_pause = rst && (e_ms || e_ds || e_hs);
  endtask

  task automatic model_advance();
    bit rel;
    rel = halted_m && pend_m && !e_ms && !e_ds;
    if (m_hold) m_hold = e_pause;
    else if (e_valid && (mem_ack || e_to)) begin
      m_age  = 0;
      m_hold = e_pause;
    end else if (e_valid) m_age = m_age + 1;
    if (e_to) m_err = 1;
    if (d_hold) d_hold = e_pause;
    else if (d_left == 1) begin
      d_left = 0;
      d_hold = e_pause;
    end else if (d_left > 1) d_left = d_left - 1;
    else if (ex_mdu_start) d_left = ex_mdu_div ? DIV_N - 1 : MUL_N - 1;
    pend_m   = (pend_m && !rel) || (dbg_step && halted_m);
    halted_m = dbg_halt;
    if (e_pause && perf_m != 32'hFFFF_FFFF) perf_m = perf_m + 1;
  endtask

  // One clock cycle: inputs already driven; compare at the falling edge, advance model at rising edge.
  task automatic run_cycle(input string tag, output logic pz, output logic dn);
    logic [31:0] perf_exp;
    @(negedge clk);
    model_eval();
    pz = pause;
    dn = mdu_done;
`ifdef STALL_PERF_EN
    perf_exp = perf_m;
`else
    perf_exp = '0;
`endif
    check({tag, "/pause"},        32'(pause),      32'(e_pause));
    check({tag, "/dmem_valid"},   32'(dmem_valid), 32'(e_valid));
    check({tag, "/mdu_done"},     32'(mdu_done),   32'(e_done));
    check({tag, "/mem_err"},      32'(mem_err),    32'(m_err));
    check({tag, "/stall_cycles"}, stall_cycles,    perf_exp);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic drive_idle();
    mem_req = 0; mem_ack = 0; ex_mdu_start = 0; ex_mdu_div = 0; dbg_halt = 0; dbg_step = 0;
  endtask

  task automatic idle_cycles(input int n);
    logic pz, dn;
    drive_idle();
    for (int i = 0; i < n; i++) run_cycle("idle", pz, dn);
  endtask

  task automatic gen_random();
    if (m_age > 0) mem_req = 1;
    else mem_req = ($urandom_range(0, 2) == 0);
    mem_ack = mem_req && !m_hold && ($urandom_range(0, 3) == 0);
    if (d_left == 0 && !d_hold) begin
      ex_mdu_start = ($urandom_range(0, 5) == 0);
      ex_mdu_div   = ($urandom_range(0, 3) == 0);
    end
    if ($urandom_range(0, 19) == 0) dbg_halt = !dbg_halt;
    dbg_step = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    logic pz_a[32];
    logic dn_a[40];
    int   cnt_p, cnt_d;

    rst = 0;
    drive_idle();
    model_reset();
    #3;
    check("reset/pause",        32'(pause),      32'd0);
    check("reset/dmem_valid",   32'(dmem_valid), 32'd0);
    check("reset/mdu_done",     32'(mdu_done),   32'd0);
    check("reset/mem_err",      32'(mem_err),    32'd0);
    check("reset/stall_cycles", stall_cycles,    32'd0);
    @(posedge clk);
    #1;
    rst = 1;
    idle_cycles(2);

    // Memory access acked three cycles after the request.
    cnt_p = 0; cnt_d = 0;
    for (int c = 0; c < 4; c++) begin
      mem_req = 1; mem_ack = (c == 3);
      run_cycle("mem_k3", pz_a[c], dn_a[c]);
      cnt_p += int'(pz_a[c]);
    end
    check("mem_k3/pause_cycles", 32'(cnt_p), 32'd3);
    check("mem_k3/pause_at_ack", 32'(pz_a[3]), 32'd0);
    idle_cycles(2);

    // Zero-wait access never stalls.
    mem_req = 1; mem_ack = 1;
    run_cycle("mem_k0", pz_a[0], dn_a[0]);
    drive_idle();
    run_cycle("mem_k0_next", pz_a[1], dn_a[1]);
    check("mem_k0/no_pause", 32'(pz_a[0] | pz_a[1]), 32'd0);
    idle_cycles(1);

    // Divide: stall 32 cycles, done on the 33rd.
    cnt_p = 0; cnt_d = 0;
    for (int c = 0; c < DIV_N; c++) begin
      ex_mdu_start = 1; ex_mdu_div = 1;
      run_cycle("div", pz_a[c % 32], dn_a[c]);
      cnt_p += int'(pz_a[c % 32]);
      cnt_d += int'(dn_a[c]);
    end
    check("div/pause_cycles", 32'(cnt_p), 32'd32);
    check("div/done_last",    32'(dn_a[DIV_N - 1]), 32'd1);
    check("div/done_count",   32'(cnt_d), 32'd1);
    idle_cycles(2);

    // Multiply overlapped with a memory access acked at cycle 7.
    cnt_d = 0;
    for (int c = 0; c < 8; c++) begin
      ex_mdu_start = 1; ex_mdu_div = 0; mem_req = 1; mem_ack = (c == 7);
      run_cycle("mul_mem", pz_a[c], dn_a[c]);
      cnt_d += int'(dn_a[c]);
    end
    check("mul_mem/done_c3",    32'(dn_a[3]), 32'd1);
    check("mul_mem/done_count", 32'(cnt_d),   32'd1);
    check("mul_mem/pause_c6",   32'(pz_a[6]), 32'd1);
    check("mul_mem/pause_c7",   32'(pz_a[7]), 32'd0);
    idle_cycles(2);

    // Timeout with no ack, then a reset in the middle of the following wait.
    cnt_p = 0;
    for (int c = 0; c < 20; c++) begin
      mem_req = 1; mem_ack = 0;
      run_cycle("timeout", pz_a[c], dn_a[c]);
      if (c < 15) cnt_p += int'(pz_a[c]);
    end
    check("timeout/pause_0_14", 32'(cnt_p),   32'd15);
    check("timeout/release",    32'(pz_a[15]), 32'd0);
    check("timeout/mem_err",    32'(mem_err),  32'd1);
    #2;
    rst = 0;
    #1;
    check("rst_mid/pause",        32'(pause),      32'd0);
    check("rst_mid/dmem_valid",   32'(dmem_valid), 32'd0);
    check("rst_mid/mdu_done",     32'(mdu_done),   32'd0);
    check("rst_mid/mem_err",      32'(mem_err),    32'd0);
    check("rst_mid/stall_cycles", stall_cycles,    32'd0);
    model_reset();
    @(posedge clk);
    #1;
    drive_idle();
    rst = 1;
    idle_cycles(2);

    // Halt from cycle 0, single step at cycle 5, halt drops at cycle 10.
    for (int c = 0; c < 12; c++) begin
      dbg_halt = (c <= 9); dbg_step = (c == 5);
      run_cycle("halt", pz_a[c], dn_a[c]);
      check("halt/pause_pattern", 32'(pz_a[c]), 32'((c >= 1 && c <= 10 && c != 6)));
    end
    idle_cycles(2);

    // Randomized traffic against the model.
    drive_idle();
    for (int i = 0; i < 3000; i++) begin
      gen_random();
      run_cycle("rand", pz_a[0], dn_a[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
